// File: rtl/vip_uart_line_capture.sv
// rtl/vip_uart_line_capture.sv - multi-channel UART RX capture presenting newline-terminated lines on one stream
module vip_uart_line_capture #(
  parameter int NumChan   = 1,
  parameter int LineDepth = 64,
  parameter int DivWidth  = 16,
  localparam int ChanW    = (NumChan > 1) ? $clog2(NumChan) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [DivWidth-1:0] clk_div_i,
  input  logic [NumChan-1:0]  uart_rx_i,
  output logic                line_valid_o,
  input  logic                line_ready_i,
  output logic [7:0]          line_data_o,
  output logic [ChanW-1:0]    line_chan_o,
  output logic                line_last_o,
  output logic [NumChan-1:0]  frame_err_o,
  output logic [NumChan-1:0]  overflow_o,
  input  logic [NumChan-1:0]  clr_i
);

  localparam int          AW      = $clog2(LineDepth);
  localparam logic [AW:0] FullC   = (AW+1)'(LineDepth);
  localparam logic [AW:0] AlmostC = (AW+1)'(LineDepth - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StData  = 3'd2;
  localparam logic [2:0] StStop  = 3'd3;
  localparam logic [2:0] StBreak = 3'd4;

  logic [NumChan-1:0]  sync1_q, sync2_q;
  logic [2:0]          state_q [NumChan];
  logic [2:0]          state_d [NumChan];
  logic [DivWidth-1:0] cnt_q   [NumChan];
  logic [DivWidth-1:0] cnt_d   [NumChan];
  logic [DivWidth-1:0] div_q   [NumChan];
  logic [DivWidth-1:0] div_d   [NumChan];
  logic [2:0]          bit_q   [NumChan];
  logic [2:0]          bit_d   [NumChan];
  logic [7:0]          shift_q [NumChan];
  logic [7:0]          shift_d [NumChan];
  logic [NumChan-1:0]  rx_push, ferr_d, ferr_q;

  logic [8:0]          mem_q   [NumChan][LineDepth];
  logic [AW-1:0]       wptr_q  [NumChan];
  logic [AW-1:0]       wptr_d  [NumChan];
  logic [AW-1:0]       rptr_q  [NumChan];
  logic [AW-1:0]       rptr_d  [NumChan];
  logic [AW:0]         occ_q   [NumChan];
  logic [AW:0]         occ_d   [NumChan];
  logic [AW:0]         pend_q  [NumChan];
  logic [AW:0]         pend_d  [NumChan];
  logic [NumChan-1:0]  ovf_q, ovf_d, do_push, push_last, pop, pop_last, has_line;

  logic                locked_q, locked_d;
  logic [ChanW-1:0]    sel_q, sel_d, rr_q, rr_d, pick;
  logic                found;
  logic [8:0]          head;

  // Two-flop synchronisers, preset to the idle-high line level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= uart_rx_i;
      sync2_q <= sync1_q;
    end
  end

  // Per-channel receive FSM: mid-bit sampling with a divisor latched at the start edge
  always_comb begin
    for (int ch = 0; ch < NumChan; ch++) begin
      state_d[ch] = state_q[ch];
      cnt_d[ch]   = cnt_q[ch];
      div_d[ch]   = div_q[ch];
      bit_d[ch]   = bit_q[ch];
      shift_d[ch] = shift_q[ch];
      rx_push[ch] = 1'b0;
      ferr_d[ch]  = 1'b0;
      case (state_q[ch])
        StIdle: begin
          if (!sync2_q[ch]) begin
            div_d[ch]   = clk_div_i;
            cnt_d[ch]   = clk_div_i >> 1;
            state_d[ch] = StStart;
          end
        end
        StStart: begin
          if (cnt_q[ch] <= DivWidth'(1)) begin
            if (!sync2_q[ch]) begin
              state_d[ch] = StData;
              bit_d[ch]   = 3'd0;
              cnt_d[ch]   = div_q[ch];
            end else begin
              state_d[ch] = StIdle;
            end
          end else begin
            cnt_d[ch] = cnt_q[ch] - DivWidth'(1);
          end
        end
        StData: begin
          if (cnt_q[ch] <= DivWidth'(1)) begin
            shift_d[ch] = {sync2_q[ch], shift_q[ch][7:1]};
            cnt_d[ch]   = div_q[ch];
            bit_d[ch]   = bit_q[ch] + 3'd1;
            if (bit_q[ch] == 3'd7) state_d[ch] = StStop;
          end else begin
            cnt_d[ch] = cnt_q[ch] - DivWidth'(1);
          end
        end
        StStop: begin
          if (cnt_q[ch] <= DivWidth'(1)) begin
            if (sync2_q[ch]) begin
              rx_push[ch] = 1'b1;
              state_d[ch] = StIdle;
            end else begin
              ferr_d[ch]  = 1'b1;
              state_d[ch] = StBreak;
            end
          end else begin
            cnt_d[ch] = cnt_q[ch] - DivWidth'(1);
          end
        end
        StBreak: begin
          if (sync2_q[ch]) state_d[ch] = StIdle;
        end
        default: state_d[ch] = StIdle;
      endcase
    end
  end

  // Line FIFO bookkeeping: forced terminator at full depth, pending-line count, sticky overflow
  always_comb begin
    for (int ch = 0; ch < NumChan; ch++) begin
      pop[ch]       = locked_q && line_ready_i && (sel_q == ChanW'(ch));
      pop_last[ch]  = pop[ch] && head[8];
      do_push[ch]   = rx_push[ch] && (occ_q[ch] != FullC);
      push_last[ch] = (shift_q[ch] == 8'h0A) || (occ_q[ch] == AlmostC);
      wptr_d[ch]    = do_push[ch] ? wptr_q[ch] + AW'(1) : wptr_q[ch];
      rptr_d[ch]    = pop[ch] ? rptr_q[ch] + AW'(1) : rptr_q[ch];
      occ_d[ch]     = occ_q[ch];
      if (do_push[ch] && !pop[ch]) occ_d[ch] = occ_q[ch] + (AW+1)'(1);
      else if (!do_push[ch] && pop[ch]) occ_d[ch] = occ_q[ch] - (AW+1)'(1);
      pend_d[ch]    = pend_q[ch];
      if ((do_push[ch] && push_last[ch]) && !pop_last[ch]) pend_d[ch] = pend_q[ch] + (AW+1)'(1);
      else if (!(do_push[ch] && push_last[ch]) && pop_last[ch]) pend_d[ch] = pend_q[ch] - (AW+1)'(1);
      ovf_d[ch]     = (ovf_q[ch] && !clr_i[ch]) || (rx_push[ch] && (occ_q[ch] == FullC));
      has_line[ch]  = (pend_q[ch] != '0);
    end
  end

  // Head entry of the channel currently locked by the arbiter
  always_comb begin
    head = '0;
    for (int ch = 0; ch < NumChan; ch++) begin
      if (sel_q == ChanW'(ch)) head = mem_q[ch][rptr_q[ch]];
    end
  end

  // Round-robin arbiter: hold one channel for a whole line, then advance past it
  always_comb begin
    locked_d = locked_q;
    sel_d    = sel_q;
    rr_d     = rr_q;
    found    = 1'b0;
    pick     = '0;
    for (int k = 0; k < NumChan; k++) begin
      for (int ch = 0; ch < NumChan; ch++) begin
        if (!found && has_line[ch] && (ch == ((int'(rr_q) + k) % NumChan))) begin
          found = 1'b1;
          pick  = ChanW'(ch);
        end
      end
    end
    if (!locked_q) begin
      if (found) begin
        locked_d = 1'b1;
        sel_d    = pick;
      end
    end else if (line_ready_i && head[8]) begin
      locked_d = 1'b0;
      rr_d     = (sel_q == ChanW'(NumChan - 1)) ? '0 : sel_q + ChanW'(1);
    end
  end

  // State registers for receivers, FIFO pointers and arbiter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int ch = 0; ch < NumChan; ch++) begin
        state_q[ch] <= StIdle;
        cnt_q[ch]   <= '0;
        div_q[ch]   <= '0;
        bit_q[ch]   <= '0;
        shift_q[ch] <= '0;
        wptr_q[ch]  <= '0;
        rptr_q[ch]  <= '0;
        occ_q[ch]   <= '0;
        pend_q[ch]  <= '0;
      end
      ferr_q   <= '0;
      ovf_q    <= '0;
      locked_q <= 1'b0;
      sel_q    <= '0;
      rr_q     <= '0;
    end else begin
      for (int ch = 0; ch < NumChan; ch++) begin
        state_q[ch] <= state_d[ch];
        cnt_q[ch]   <= cnt_d[ch];
        div_q[ch]   <= div_d[ch];
        bit_q[ch]   <= bit_d[ch];
        shift_q[ch] <= shift_d[ch];
        wptr_q[ch]  <= wptr_d[ch];
        rptr_q[ch]  <= rptr_d[ch];
        occ_q[ch]   <= occ_d[ch];
        pend_q[ch]  <= pend_d[ch];
      end
      ferr_q   <= ferr_d;
      ovf_q    <= ovf_d;
      locked_q <= locked_d;
      sel_q    <= sel_d;
      rr_q     <= rr_d;
    end
  end

  // FIFO storage; contents are meaningless after reset because the pointers are cleared
  always_ff @(posedge clk_i) begin
    for (int ch = 0; ch < NumChan; ch++) begin
      if (do_push[ch]) mem_q[ch][wptr_q[ch]] <= {push_last[ch], shift_q[ch]};
    end
  end

  assign line_valid_o = locked_q;
  assign line_data_o  = locked_q ? head[7:0] : 8'h00;
  assign line_last_o  = locked_q && head[8];
  assign line_chan_o  = locked_q ? sel_q : '0;
  assign frame_err_o  = ferr_q;
  assign overflow_o   = ovf_q;

endmodule
